// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bus shared by all sources competing for the regfile write port.
// master = writeback sources, slave = arbiter.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single regfile write port between NREQ writeback sources and registers the winner.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int IW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  req,
  input  logic                 flush,
  output logic                 we,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata,
  output logic [IW-1:0]        grant_id
);

  logic          win_any;
  logic [IW-1:0] win_idx;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          transfer;

`ifdef WB_ARB_RR_EN
  logic [IW-1:0] last;
  int            dist;
  int            best_dist;

  // Each valid requester gets its distance from last+1 (mod NREQ); the smallest distance wins.
  always_comb begin
    win_any   = 1'b0;
    win_idx   = '0;
    dist      = 0;
    best_dist = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      dist = (i + 2 * NREQ - int'(last) - 1) % NREQ;
      if (req.req_valid[i] && (dist < best_dist)) begin
        best_dist = dist;
        win_any   = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= IW'(NREQ - 1);
    end else if (transfer) begin
      last <= win_idx;
    end
  end
`else
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req.req_valid[i]) begin
        win_any = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`endif

  assign transfer = win_any && !flush;

  always_comb begin
    req.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req.req_ready[i] = transfer && (win_idx == IW'(i));
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_addr = req.req_addr[i*AW +: AW];
        win_data = req.req_data[i*DW +: DW];
      end
    end
  end

  // An accepted write to register 0 is consumed but never raises we.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      grant_id <= '0;
    end else begin
      we <= transfer && (win_addr != '0);
      if (transfer) begin
        waddr    <= win_addr;
        wdata    <= win_data;
        grant_id <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter; expectations follow WB_ARB_RR_EN.
module tb_regfile_wr_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IW   = 3;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [IW-1:0] grant_id;

  int test_count = 0;
  int fail_count = 0;
  int exp_id;
  int gap;
  int waited;
  logic got;

  logic [DW-1:0] rf [32] = '{default: '0};

  regfile_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus),
    .flush    (flush),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: writes any address so a stray write to register 0 is visible.
  always @(posedge clk) begin
    if (we) rf[waddr] <= wdata;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ*AW-1:0] addr,
                               input logic [NREQ*DW-1:0] data, input logic fl);
    bus.req_valid = valid;
    bus.req_addr  = addr;
    bus.req_data  = data;
    flush         = fl;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus('0, '0, '0, 1'b0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_we", we, 0);
    checkOutput("rst_waddr", waddr, 0);
    checkOutput("rst_wdata", wdata, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    rst = 1'b1;

    // All three requesters valid for three cycles.
    for (int c = 0; c < 3; c++) begin
`ifdef WB_ARB_RR_EN
      exp_id = c;
`else
      exp_id = 0;
`endif
      applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC0, 32'hB0, 32'hA0}, 1'b0);
      #1 checkOutput("t1_ready", bus.req_ready, 64'(1 << exp_id));
      @(negedge clk);
      checkOutput("t1_we", we, 1);
      checkOutput("t1_waddr", waddr, 64'(exp_id + 1));
      checkOutput("t1_wdata", wdata, 64'(32'hA0 + exp_id * 32'h10));
      checkOutput("t1_grant_id", grant_id, 64'(exp_id));
    end
    applyStimulus('0, {5'd3, 5'd2, 5'd1}, {32'hC0, 32'hB0, 32'hA0}, 1'b0);
    #1 checkOutput("idle_ready", bus.req_ready, 0);
    @(negedge clk);
    checkOutput("idle_we", we, 0);
    checkOutput("idle_waddr_hold", waddr, 64'(exp_id + 1));

    // Single requester back-to-back.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b0);
      #1 checkOutput("t2_ready", bus.req_ready, 3'b010);
      @(negedge clk);
      checkOutput("t2_we", we, 1);
      checkOutput("t2_waddr", waddr, 7);
      checkOutput("t2_wdata", wdata, 32'hDEADBEEF);
      checkOutput("t2_grant_id", grant_id, 1);
    end

    // Write to register 0 is accepted but suppressed.
    applyStimulus(3'b100, {5'd0, 5'd0, 5'd0}, {32'hFFFFFFFF, 32'h0, 32'h0}, 1'b0);
    #1 checkOutput("t3_ready", bus.req_ready, 3'b100);
    @(negedge clk);
    checkOutput("t3_we", we, 0);
    applyStimulus('0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t3_rf0", rf[0], 0);
    checkOutput("t3_rf7", rf[7], 32'hDEADBEEF);

    // Flush blocks the grant and leaves the pointer alone.
    applyStimulus(3'b011, {5'd0, 5'd6, 5'd4}, {32'h0, 32'h66, 32'h44}, 1'b1);
    #1 checkOutput("t4_flush_ready", bus.req_ready, 0);
    @(negedge clk);
    checkOutput("t4_flush_we", we, 0);
    applyStimulus(3'b011, {5'd0, 5'd6, 5'd4}, {32'h0, 32'h66, 32'h44}, 1'b0);
    #1 checkOutput("t4_post_ready", bus.req_ready, 3'b001);
    @(negedge clk);
    checkOutput("t4_post_we", we, 1);
    checkOutput("t4_post_waddr", waddr, 4);
    checkOutput("t4_post_grant_id", grant_id, 0);
`ifdef WB_ARB_RR_EN
    exp_id = 1;
`else
    exp_id = 0;
`endif
    #1 checkOutput("t4_next_ready", bus.req_ready, 64'(1 << exp_id));
    @(negedge clk);
    checkOutput("t4_next_grant_id", grant_id, 64'(exp_id));

    // Transfer from requester 1 to addr 5, then reset in the following cycle.
    applyStimulus(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'h55, 32'h0}, 1'b0);
    #1 checkOutput("t5_ready", bus.req_ready, 3'b010);
    @(negedge clk);
    checkOutput("t5_we", we, 1);
    checkOutput("t5_waddr", waddr, 5);
    applyStimulus('0, '0, '0, 1'b0);
    #2 rst = 1'b0;
    #1 checkOutput("t5_async_we", we, 0);
    checkOutput("t5_async_waddr", waddr, 0);
    checkOutput("t5_async_grant_id", grant_id, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(3'b110, {5'd9, 5'd8, 5'd0}, {32'h99, 32'h88, 32'h0}, 1'b0);
    #1 checkOutput("t5_first_ready", bus.req_ready, 3'b010);
    @(negedge clk);
    checkOutput("t5_first_we", we, 1);
    checkOutput("t5_first_waddr", waddr, 8);
    checkOutput("t5_first_grant_id", grant_id, 1);
`ifdef WB_ARB_RR_EN
    exp_id = 2;
`else
    exp_id = 1;
`endif
    #1 checkOutput("t5_second_ready", bus.req_ready, 64'(1 << exp_id));
    @(negedge clk);
    checkOutput("t5_second_grant_id", grant_id, 64'(exp_id));
    applyStimulus('0, '0, '0, 1'b0);
    @(negedge clk);

`ifdef WB_ARB_RR_EN
    // Requester 2 joins at random points while 0 and 1 stay busy.
    for (int n = 0; n < 6; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(3'b011, {5'd12, 5'd11, 5'd10}, {32'h12, 32'h11, 32'h10}, 1'b0);
        @(negedge clk);
      end
      applyStimulus(3'b111, {5'd12, 5'd11, 5'd10}, {32'h12, 32'h11, 32'h10}, 1'b0);
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 8) begin
        #1 got = bus.req_ready[2];
        waited++;
        @(negedge clk);
      end
      checkOutput("rr_starve_bound", 64'(got && (waited <= NREQ)), 1);
    end
`else
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b111, {5'd12, 5'd11, 5'd10}, {32'h12, 32'h11, 32'h10}, 1'b0);
      #1 checkOutput("fp_ready", bus.req_ready, 3'b001);
      @(negedge clk);
      checkOutput("fp_grant_id", grant_id, 0);
    end
`endif

    applyStimulus('0, '0, '0, 1'b0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end
endmodule
